// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - captures operand A, operand B and opcode from a shared bus on successive load strobes
module operand_loader #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [2:0]   opcode_o,
    output logic         valid_o,
    output logic         issue_o,
    output logic [1:0]   state_o
);

    localparam logic [1:0] S_A   = 2'b00;
    localparam logic [1:0] S_B   = 2'b01;
    localparam logic [1:0] S_OP  = 2'b10;
    localparam logic [1:0] S_RUN = 2'b11;

    logic       load_q;
    logic       load_evt;
    logic [1:0] state;
    logic [1:0] next_state;

    assign load_evt = load_i & ~load_q;

    always_comb begin
        next_state = state;
        if (load_evt) begin
            case (state)
                S_A:     next_state = S_B;
                S_B:     next_state = S_OP;
                S_OP:    next_state = S_RUN;
                default: next_state = S_B;
            endcase
        end
    end

    // load_q tracks the strobe even during reset/clear so a held strobe never fires on release
    always_ff @(posedge clk_i) begin
        load_q <= load_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state    <= S_A;
            a_o      <= '0;
            b_o      <= '0;
            opcode_o <= 3'b000;
            valid_o  <= 1'b0;
            issue_o  <= 1'b0;
        end else begin
            state   <= next_state;
            valid_o <= (next_state == S_RUN);
            issue_o <= load_evt && (state == S_OP);
            if (load_evt) begin
                case (state)
                    S_B:     b_o      <= data_i;
                    S_OP:    opcode_o <= data_i[2:0];
                    default: a_o      <= data_i;
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - randomized and directed check of operand_loader at N=4 and N=8
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] data = 8'h00;

    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic [2:0] op4, op8;
    logic       valid4, valid8, issue4, issue8;
    logic [1:0] state4, state8;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    operand_loader #(.N(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .clear_i(clear), .data_i(data[3:0]),
        .a_o(a4), .b_o(b4), .opcode_o(op4), .valid_o(valid4), .issue_o(issue4), .state_o(state4)
    );

    operand_loader #(.N(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .load_i(load), .clear_i(clear), .data_i(data),
        .a_o(a8), .b_o(b8), .opcode_o(op8), .valid_o(valid8), .issue_o(issue8), .state_o(state8)
    );

    // Reference: number of operands captured so far in the current set (0..3)
    int       m_count = 0;
    bit       m_prev = 1'b0;
    bit       m_issue = 1'b0;
    int       m_a = 0, m_b = 0, m_op = 0;

    always @(posedge clk) begin
        bit ev;
        ev = load && !m_prev;
        m_prev = load;
        m_issue = 1'b0;
        if (rst || clear) begin
            m_count = 0; m_a = 0; m_b = 0; m_op = 0;
        end else if (ev) begin
            if (m_count == 0 || m_count == 3) begin
                m_a = data; m_count = 1;
            end else if (m_count == 1) begin
                m_b = data; m_count = 2;
            end else begin
                m_op = data % 8; m_count = 3; m_issue = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a4", a4, m_a % 16);
            check("b4", b4, m_b % 16);
            check("op4", op4, m_op);
            check("valid4", valid4, m_count == 3);
            check("issue4", issue4, m_issue);
            check("state4", state4, m_count);
            check("a8", a8, m_a);
            check("b8", b8, m_b);
            check("op8", op8, m_op);
            check("valid8", valid8, m_count == 3);
            check("issue8", issue8, m_issue);
            check("state8", state8, m_count);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] d);
        load = 1'b1; data = d;
        cyc(1);
        load = 1'b0; data = ~d;
        cyc(1);
    endtask

    initial begin
        // Reset held with strobe high, then released while strobe stays high
        rst = 1'b1; load = 1'b1; data = 8'h0C;
        cyc(2);
        cmp_en = 1'b1;
        rst = 1'b0;
        cyc(3);
        check("rst_state", state4, 0);
        check("rst_a", a4, 0);
        check("rst_valid", valid4, 0);
        load = 1'b0;
        cyc(1);

        // Held strobe captures only once
        load = 1'b1; data = 8'h07;
        cyc(10);
        check("held_a", a4, 4'h7);
        check("held_state", state4, 2'b01);
        load = 1'b0;
        cyc(1);
        rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);

        // Full load
        strobe(8'h0A);
        strobe(8'h03);
        load = 1'b1; data = 8'h05;
        cyc(1);
        check("full_issue_hi", issue4, 1);
        check("full_valid", valid4, 1);
        load = 1'b0;
        cyc(1);
        check("full_issue_lo", issue4, 0);
        check("full_a", a4, 4'hA);
        check("full_b", b4, 4'h3);
        check("full_op", op4, 3'b101);
        check("full_state", state4, 2'b11);

        // Restart from S_RUN
        strobe(8'h0F);
        check("restart_a", a4, 4'hF);
        check("restart_b", b4, 4'h3);
        check("restart_op", op4, 3'b101);
        check("restart_valid", valid4, 0);
        check("restart_state", state4, 2'b01);

        // Clear coincident with an event in S_OP
        strobe(8'h09);
        check("pre_clear_state", state4, 2'b10);
        clear = 1'b1; load = 1'b1; data = 8'h06;
        cyc(1);
        clear = 1'b0; load = 1'b0;
        cyc(1);
        check("clear_state", state4, 0);
        check("clear_a", a4, 0);
        check("clear_op", op4, 0);

        // Opcode truncation at N=8
        strobe(8'h11);
        strobe(8'h22);
        strobe(8'hFE);
        check("trunc_op8", op8, 3'b110);
        check("trunc_a8", a8, 8'h11);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) load = ~load;
            data  = 8'($urandom);
            cyc(1);
        end
        rst = 1'b0; clear = 1'b0; load = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
